// File: rtl/key_matrix_scanner_pkg.sv
// key_matrix_scanner_pkg
// Shared definitions for the key matrix scanner: event field layout,
// scan FSM state encoding, default timing constants and an event packer.
package key_matrix_scanner_pkg;

  // Event byte layout: {press, col[3:0], row[2:0]}
  localparam int PRESS_BIT = 7;
  localparam int COL_LSB   = 3;
  localparam int ROW_LSB   = 0;

  localparam int DEF_COLS          = 9;
  localparam int DEF_PERIOD_CYCLES = 524288;
  localparam int DEF_DRAIN_CYCLES  = 1000;
  localparam int DEF_SETTLE_CYCLES = 500;
  localparam int DEF_DEBOUNCE      = 3;
  localparam int DEF_FIFO_DEPTH    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_SCAN    = 3'd4,
    ST_RESTORE = 3'd5
  } scan_state_e;

  function automatic logic [7:0] pack_event(input logic       press,
                                            input logic [3:0] col,
                                            input logic [2:0] row);
    logic [7:0] ev;
    ev                = '0;
    ev[PRESS_BIT]     = press;
    ev[COL_LSB +: 4]  = col;
    ev[ROW_LSB +: 3]  = row;
    return ev;
  endfunction

endpackage

// File: rtl/key_matrix_scanner_event_fifo.sv
// event_fifo
// Synchronous FIFO for key events. A push and a pop in the same cycle are
// both honoured, including when the FIFO is full. Read data comes straight
// from the storage registers at the read pointer.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_data      write request and data
//   i_pop               read request (ignored when empty)
//   o_data              head entry
//   o_full, o_empty     occupancy flags
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot this cycle, so a full FIFO still accepts the push.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner
// Scans a key matrix whose rows share the LCD data bus, debounces each key
// and queues press/release events. The bus is borrowed one column at a time
// by pausing the LCD through its frame strobe.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   lcd_frame_strobe     1 = LCD may run, 0 = LCD must idle
//   lcd_output_en        1 = LCD drives shared pins, 0 = pins are inputs
//   col_drive            active-low column drive, all ones when idle
//   key_row              raw row pins, active-low
//   event_valid/ready    event handshake
//   event_data           {press, col[3:0], row[2:0]}
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | LCD owns the bus; wait out the column period
// ST_DRAIN   | frame strobe low; give the LCD time to finish and idle
// ST_DRIVE   | bus turned around, one column driven; wait for rows to settle
// ST_SAMPLE  | capture closed keys of the driven column
// ST_SCAN    | debounce one row per cycle, push events
// ST_RESTORE | release column, hand bus back to LCD, advance column
module key_matrix_scanner
  import key_matrix_scanner_pkg::*;
#(
  parameter int COLS          = DEF_COLS,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  output logic            lcd_frame_strobe,
  output logic            lcd_output_en,
  output logic [COLS-1:0] col_drive,
  input  logic [7:0]      key_row,
  output logic            event_valid,
  input  logic            event_ready,
  output logic [7:0]      event_data
);

  localparam int TMR_MAX = (PERIOD_CYCLES > DRAIN_CYCLES)
                         ? ((PERIOD_CYCLES > SETTLE_CYCLES) ? PERIOD_CYCLES : SETTLE_CYCLES)
                         : ((DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(COLS * 8);

  scan_state_e                 r_state;
  logic [TMR_W-1:0]            r_timer;
  logic [3:0]                  r_col;
  logic [2:0]                  r_row;
  logic [7:0]                  r_row_meta;
  logic [7:0]                  r_row_sync;
  logic [7:0]                  r_hit;
  logic [COLS*8-1:0]           r_stable;
  logic [COLS*8-1:0][1:0]      r_cnt;

  logic [COLS-1:0]             w_col_sel;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_hit_bit;
  logic                        w_differs;
  logic [2:0]                  w_cnt_next;
  logic                        w_reached;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;
  logic                        w_can_push;
  logic                        w_push;
  logic [7:0]                  w_push_data;

  assign w_col_sel   = COLS'(1) << r_col;
  assign w_idx       = IDX_W'({r_col, r_row});
  assign w_hit_bit   = r_hit[r_row];
  assign w_differs   = (r_state == ST_SCAN) && (w_hit_bit != r_stable[w_idx]);
  assign w_cnt_next  = {1'b0, r_cnt[w_idx]} + 3'd1;
  assign w_reached   = (w_cnt_next >= 3'(DEBOUNCE));
  assign w_pop       = event_valid && event_ready;
  assign w_can_push  = !w_full || w_pop;
  assign w_push      = w_differs && w_reached && w_can_push;
  assign w_push_data = pack_event(w_hit_bit, r_col, r_row);
  assign event_valid = !w_empty;

  // Rows are asynchronous pins; two flops keep metastability out of the
  // debounce logic. Settle time covers the extra latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
    end else begin
      r_row_meta <= key_row;
      r_row_sync <= r_row_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_timer          <= TMR_W'(PERIOD_CYCLES - 1);
      r_col            <= '0;
      r_row            <= '0;
      r_hit            <= '0;
      r_stable         <= '0;
      r_cnt            <= '0;
      lcd_frame_strobe <= 1'b1;
      lcd_output_en    <= 1'b1;
      col_drive        <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_timer == '0) begin
            r_state          <= ST_DRAIN;
            r_timer          <= TMR_W'(DRAIN_CYCLES - 1);
            lcd_frame_strobe <= 1'b0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (r_timer == '0) begin
            r_state       <= ST_DRIVE;
            r_timer       <= TMR_W'(SETTLE_CYCLES - 1);
            lcd_output_en <= 1'b0;
            col_drive     <= ~w_col_sel;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_DRIVE: begin
          if (r_timer == '0) r_state <= ST_SAMPLE;
          else               r_timer <= r_timer - TMR_W'(1);
        end
        ST_SAMPLE: begin
          r_hit   <= ~r_row_sync;
          r_row   <= '0;
          r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!w_differs) begin
            r_cnt[w_idx] <= '0;
          end else if (w_push) begin
            r_stable[w_idx] <= w_hit_bit;
            r_cnt[w_idx]    <= '0;
          end else if (w_reached) begin
            // FIFO full: hold at threshold so the next visit retries the push.
            r_cnt[w_idx] <= 2'(DEBOUNCE);
          end else begin
            r_cnt[w_idx] <= w_cnt_next[1:0];
          end
          r_row <= r_row + 3'd1;
          if (r_row == 3'd7) r_state <= ST_RESTORE;
        end
        ST_RESTORE: begin
          col_drive        <= '1;
          lcd_output_en    <= 1'b1;
          lcd_frame_strobe <= 1'b1;
          r_col            <= (r_col == 4'(COLS - 1)) ? 4'd0 : r_col + 4'd1;
          r_timer          <= TMR_W'(PERIOD_CYCLES - 1);
          r_state          <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  event_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (event_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner
// Scoreboard bench: expected events are queued when keys change and
// compared as the DUT hands them out. A bus monitor watches the
// strobe / output-enable / column ordering continuously.
module tb_key_matrix_scanner;

  localparam int COLS = 9;
  localparam int PER  = 40;
  localparam int DRN  = 6;
  localparam int STL  = 4;
  localparam int DEB  = 3;
  localparam int DEP  = 8;
  localparam int SLOT = PER + DRN + STL + 1 + 8 + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            lcd_frame_strobe;
  logic            lcd_output_en;
  logic [COLS-1:0] col_drive;
  logic [7:0]      key_row;
  logic            event_valid;
  logic            event_ready;
  logic [7:0]      event_data;

  logic [7:0]      keys [COLS];
  logic [7:0]      exp_q [$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  int              n_drained;

  int              kc [10] = '{1, 1, 1, 1, 4, 4, 6, 6, 8, 8};
  int              kr [10] = '{0, 1, 2, 3, 2, 6, 0, 7, 3, 4};

  key_matrix_scanner #(
    .COLS          (COLS),
    .PERIOD_CYCLES (PER),
    .DRAIN_CYCLES  (DRN),
    .SETTLE_CYCLES (STL),
    .DEBOUNCE      (DEB),
    .FIFO_DEPTH    (DEP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .lcd_frame_strobe (lcd_frame_strobe),
    .lcd_output_en    (lcd_output_en),
    .col_drive        (col_drive),
    .key_row          (key_row),
    .event_valid      (event_valid),
    .event_ready      (event_ready),
    .event_data       (event_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Matrix model: a closed key pulls its row low while its column is driven.
  always_comb begin
    key_row = 8'hFF;
    for (int c = 0; c < COLS; c++)
      if (!col_drive[c]) key_row = key_row & ~keys[c];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=timeout expected=event", tag);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  endtask

  function automatic logic [COLS-1:0] colpat(input int c);
    logic [COLS-1:0] v;
    v    = '1;
    v[c] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] ev(input bit p, input int c, input int r);
    return {p, 4'(c), 3'(r)};
  endfunction

  // Returns 1 ns after the edge on which the bus turns around for column c.
  task automatic wait_col(input int c);
    logic p;
    p = lcd_output_en;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (p && !lcd_output_en && col_drive == colpat(c)) return;
      p = lcd_output_en;
    end
    tmo("wait_col");
  endtask

  task automatic wait_oe_high();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (lcd_output_en) return;
    end
    tmo("wait_oe_high");
  endtask

  // Scoreboard consumer: a handshake seen at negedge completes at next posedge.
  always @(negedge clk) begin
    if (reset && event_valid && event_ready) begin
      chk("ev_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("ev_data", event_data, exp_q.pop_front());
    end
  end

  // Bus safety monitor.
  logic            p_strobe = 1'b1;
  logic            p_oe = 1'b1;
  logic [COLS-1:0] p_col = '1;
  int              t_sfall = 0;
  int              t_ofall = -1;
  int              exp_col = 0;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      p_strobe = 1'b1;
      p_oe     = 1'b1;
      p_col    = '1;
      t_ofall  = -1;
      exp_col  = 0;
    end else begin
      if (p_strobe && !lcd_frame_strobe) t_sfall = cyc;
      if (col_drive != p_col) chk("col_with_oe", 32'(lcd_output_en != p_oe), 1);
      if (p_oe && !lcd_output_en) begin
        chk("drain_gap", 32'((cyc - t_sfall) >= DRN), 1);
        chk("col_pat", col_drive, colpat(exp_col));
        if (t_ofall >= 0) chk("slot_period", cyc - t_ofall, SLOT);
        t_ofall = cyc;
        exp_col = (exp_col + 1) % COLS;
      end
      if (!p_oe && lcd_output_en) chk("oe_rise_cols", col_drive, {COLS{1'b1}});
      p_strobe = lcd_frame_strobe;
      p_oe     = lcd_output_en;
      p_col    = col_drive;
    end
  end

  initial begin
    for (int c = 0; c < COLS; c++) keys[c] = 8'h00;
    event_ready = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_strobe", lcd_frame_strobe, 1);
    chk("rst_oe", lcd_output_en, 1);
    chk("rst_cols", col_drive, {COLS{1'b1}});
    chk("rst_valid", event_valid, 0);
    chk("rst_data", event_data, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Idle matrix: two full sweeps, nothing reported.
    repeat (2) wait_col(0);
    chk("idle_valid", event_valid, 0);
    chk("idle_q", exp_q.size(), 0);

    // Single key press then release.
    wait_col(0);
    keys[2][5] = 1'b1;
    exp_q.push_back(ev(1, 2, 5));
    repeat (4) wait_col(0);
    chk("press_done", exp_q.size(), 0);
    keys[2][5] = 1'b0;
    exp_q.push_back(ev(0, 2, 5));
    repeat (4) wait_col(0);
    chk("release_done", exp_q.size(), 0);

    // Bounce: closed on alternate visits only.
    for (int i = 0; i < 8; i++) begin
      wait_col(0);
      keys[3][1] = (i % 2 == 0);
    end
    wait_col(0);
    keys[3] = 8'h00;
    repeat (3) wait_col(0);
    chk("bounce_valid", event_valid, 0);
    chk("bounce_q", exp_q.size(), 0);

    // Ten presses with the consumer stalled: eight fit, two are retried.
    event_ready = 1'b0;
    wait_col(0);
    for (int k = 0; k < 10; k++) begin
      keys[kc[k]][kr[k]] = 1'b1;
      exp_q.push_back(ev(1, kc[k], kr[k]));
    end
    repeat (3) wait_col(0);
    chk("full_valid", event_valid, 1);
    // Pop exactly while row 3 of column 8 is scanned: push and pop coincide.
    wait_col(8);
    repeat (STL + 4) @(posedge clk);
    #1 event_ready = 1'b1;
    @(posedge clk);
    #1 event_ready = 1'b0;
    wait_oe_high();
    event_ready = 1'b1;
    n_drained = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (event_valid) n_drained++;
      else break;
    end
    chk("full_occupancy", n_drained, DEP);
    repeat (2) wait_col(0);
    chk("retry_done", exp_q.size(), 0);

    wait_col(0);
    for (int k = 0; k < 10; k++) begin
      keys[kc[k]][kr[k]] = 1'b0;
      exp_q.push_back(ev(0, kc[k], kr[k]));
    end
    repeat (4) wait_col(0);
    chk("multi_release", exp_q.size(), 0);

    // Reset in the middle of a column slot with an event still queued.
    event_ready = 1'b0;
    wait_col(0);
    keys[5][5] = 1'b1;
    exp_q.push_back(ev(1, 5, 5));
    repeat (3) wait_col(0);
    chk("pre_rst_valid", event_valid, 1);
    chk("pre_rst_data", event_data, ev(1, 5, 5));
    wait_col(3);
    #2 reset = 1'b0;
    #1;
    chk("midrst_cols", col_drive, {COLS{1'b1}});
    chk("midrst_oe", lcd_output_en, 1);
    chk("midrst_strobe", lcd_frame_strobe, 1);
    chk("midrst_valid", event_valid, 0);
    keys[5] = 8'h00;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", event_valid, 0);
    event_ready = 1'b1;
    repeat (3) wait_col(0);
    chk("final_valid", event_valid, 0);
    chk("final_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
